// File: rtl/dd_bm_sequencer.sv
// Buffer-manager sequencer for the 64DD sector buffer: walks sectors through
// fill/drain copies, N64 handshakes, C2 phases and optional second block.
module dd_bm_sequencer #(
  parameter int DATA_SECTORS = 85,
  parameter int BLOCK1_BASE  = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bm_start_pending,
  input  logic       bm_stop_pending,
  input  logic       bm_transfer_mode,
  input  logic       bm_transfer_blocks,
  input  logic       bm_pending,
  input  logic [7:0] sector_num,
  input  logic       disk_inserted,
  output logic       bm_start_clear,
  output logic       bm_stop_clear,
  output logic       bm_clear,
  output logic       bm_ready,
  output logic       bm_transfer_data,
  output logic       bm_transfer_c2,
  output logic       bm_micro_error,
  output logic       copy_req,
  output logic       copy_write,
  output logic [7:0] copy_sector,
  input  logic       copy_done,
  output logic       busy
);

  localparam logic [7:0] BASE1    = 8'(BLOCK1_BASE);
  localparam logic [7:0] LAST_OFS = 8'(DATA_SECTORS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WAIT_N64,
    S_DRAIN,
    S_C2,
    S_ERROR
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] cur_sector_reg, cur_sector_next;
  logic       blk_reg, blk_next;
  logic       mode_reg, mode_next;
  logic       blocks_reg, blocks_next;
  logic       ready_due_reg, ready_due_next;
  logic       start_clear_reg, start_clear_next;
  logic       stop_clear_reg, stop_clear_next;
  logic       clear_reg, clear_next;
  logic       ready_reg, ready_next;
  logic       data_reg, data_next;
  logic       c2_reg, c2_next;
  logic       micro_error_reg, micro_error_next;
  logic       copy_req_reg, copy_req_next;
  logic       copy_write_reg, copy_write_next;

  logic [7:0] blk_base;
  logic [7:0] blk_ofs;
  logic       last;
  logic       more_block;

  // Offset within the current block; 255 also terminates so an odd start
  // sector can never run the counter past the top of the 8-bit range.
  always_comb begin
    blk_base   = blk_reg ? BASE1 : 8'd0;
    blk_ofs    = cur_sector_reg - blk_base;
    last       = (blk_ofs == LAST_OFS) || (cur_sector_reg == 8'hFF);
    more_block = blocks_reg && !blk_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      cur_sector_reg  <= 8'd0;
      blk_reg         <= 1'b0;
      mode_reg        <= 1'b0;
      blocks_reg      <= 1'b0;
      ready_due_reg   <= 1'b0;
      start_clear_reg <= 1'b0;
      stop_clear_reg  <= 1'b0;
      clear_reg       <= 1'b0;
      ready_reg       <= 1'b0;
      data_reg        <= 1'b0;
      c2_reg          <= 1'b0;
      micro_error_reg <= 1'b0;
      copy_req_reg    <= 1'b0;
      copy_write_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cur_sector_reg  <= cur_sector_next;
      blk_reg         <= blk_next;
      mode_reg        <= mode_next;
      blocks_reg      <= blocks_next;
      ready_due_reg   <= ready_due_next;
      start_clear_reg <= start_clear_next;
      stop_clear_reg  <= stop_clear_next;
      clear_reg       <= clear_next;
      ready_reg       <= ready_next;
      data_reg        <= data_next;
      c2_reg          <= c2_next;
      micro_error_reg <= micro_error_next;
      copy_req_reg    <= copy_req_next;
      copy_write_reg  <= copy_write_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cur_sector_next  = cur_sector_reg;
    blk_next         = blk_reg;
    mode_next        = mode_reg;
    blocks_next      = blocks_reg;
    ready_due_next   = ready_due_reg;
    start_clear_next = 1'b0;
    stop_clear_next  = 1'b0;
    clear_next       = 1'b0;
    ready_next       = 1'b0;
    data_next        = data_reg;
    c2_next          = c2_reg;
    micro_error_next = micro_error_reg;
    copy_req_next    = copy_req_reg;
    copy_write_next  = copy_write_reg;

    if (bm_stop_pending) begin
      stop_clear_next = 1'b1;
      copy_req_next   = 1'b0;
      data_next       = 1'b0;
      c2_next         = 1'b0;
      ready_due_next  = 1'b0;
      state_next      = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bm_start_pending) begin
            start_clear_next = 1'b1;
            cur_sector_next  = sector_num;
            blk_next         = (sector_num >= BASE1);
            mode_next        = bm_transfer_mode;
            blocks_next      = bm_transfer_blocks;
            data_next        = 1'b0;
            c2_next          = 1'b0;
            if (!disk_inserted) begin
              micro_error_next = 1'b1;
              state_next       = S_ERROR;
            end else begin
              micro_error_next = 1'b0;
              if (bm_transfer_mode) begin
                copy_req_next   = 1'b1;
                copy_write_next = 1'b0;
                state_next      = S_FILL;
              end else begin
                // Interrupt follows one cycle later so it never shares a
                // cycle with the start-clear pulse.
                data_next      = 1'b1;
                ready_due_next = 1'b1;
                state_next     = S_WAIT_N64;
              end
            end
          end
        end

        S_ERROR: begin
          ready_next = 1'b1;
          state_next = S_IDLE;
        end

        S_FILL: begin
          if (copy_done) begin
            copy_req_next = 1'b0;
            data_next     = 1'b1;
            ready_next    = 1'b1;
            state_next    = S_WAIT_N64;
          end
        end

        S_WAIT_N64: begin
          if (ready_due_reg) begin
            ready_next     = 1'b1;
            ready_due_next = 1'b0;
          end else if (bm_pending) begin
            clear_next = 1'b1;
            if (mode_reg) begin
              if (!last) begin
                cur_sector_next = cur_sector_reg + 8'd1;
                copy_req_next   = 1'b1;
                copy_write_next = 1'b0;
                state_next      = S_FILL;
              end else begin
                data_next  = 1'b0;
                c2_next    = 1'b1;
                ready_next = 1'b1;
                state_next = S_C2;
              end
            end else begin
              copy_req_next   = 1'b1;
              copy_write_next = 1'b1;
              state_next      = S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          if (copy_done) begin
            copy_req_next = 1'b0;
            if (!last) begin
              cur_sector_next = cur_sector_reg + 8'd1;
              ready_next      = 1'b1;
              state_next      = S_WAIT_N64;
            end else if (more_block) begin
              blk_next        = 1'b1;
              cur_sector_next = BASE1;
              ready_next      = 1'b1;
              state_next      = S_WAIT_N64;
            end else begin
              data_next  = 1'b0;
              state_next = S_IDLE;
            end
          end
        end

        S_C2: begin
          if (bm_pending) begin
            clear_next = 1'b1;
            c2_next    = 1'b0;
            if (more_block) begin
              blk_next        = 1'b1;
              cur_sector_next = BASE1;
              copy_req_next   = 1'b1;
              copy_write_next = 1'b0;
              state_next      = S_FILL;
            end else begin
              data_next  = 1'b0;
              state_next = S_IDLE;
            end
          end
        end

        default: state_next = S_IDLE;
      endcase
    end
  end

  // The request is masked by copy_done so the engine sees it fall in the
  // completion cycle rather than one cycle late.
  assign copy_req         = copy_req_reg & ~copy_done;
  assign copy_write       = copy_write_reg;
  assign copy_sector      = cur_sector_reg;
  assign bm_start_clear   = start_clear_reg;
  assign bm_stop_clear    = stop_clear_reg;
  assign bm_clear         = clear_reg;
  assign bm_ready         = ready_reg;
  assign bm_transfer_data = data_reg;
  assign bm_transfer_c2   = c2_reg;
  assign bm_micro_error   = micro_error_reg;
  assign busy             = (state_reg != S_IDLE);

endmodule

// File: doc/dd_bm_sequencer.md
DD_BM_SEQUENCER -- requirements
Module: dd_bm_sequencer

Interface
REQ-001 SHALL have parameter DATA_SECTORS, default 85, giving the number of user sectors per block.
REQ-002 SHALL have parameter BLOCK1_BASE, default 90, giving the sector number of the first sector of block 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port bm_start_pending, input, 1 bit: N64 requested buffer-manager start.
REQ-006 SHALL have port bm_stop_pending, input, 1 bit: N64 requested buffer-manager reset.
REQ-007 SHALL have port bm_transfer_mode, input, 1 bit: 1 = disk read (buffer to N64); 0 = disk write.
REQ-008 SHALL have port bm_transfer_blocks, input, 1 bit: two-block transfer enabled.
REQ-009 SHALL have port bm_pending, input, 1 bit: N64 reached the end of the sector buffer.
REQ-010 SHALL have port sector_num, input, 8 bits: starting sector number.
REQ-011 SHALL have port disk_inserted, input, 1 bit: a disk image is present.
REQ-012 SHALL have ports bm_start_clear, bm_stop_clear and bm_clear, each output, 1 bit: one-cycle clear pulses.
REQ-013 SHALL have port bm_ready, output, 1 bit: one-cycle pulse that raises the buffer-manager interrupt.
REQ-014 SHALL have ports bm_transfer_data and bm_transfer_c2, each output, 1 bit: status levels.
REQ-015 SHALL have port bm_micro_error, output, 1 bit: status level.
REQ-016 SHALL have port copy_req, output, 1 bit: request to the sector copy engine; held until copy_done.
REQ-017 SHALL have port copy_write, output, 1 bit: 1 = buffer to memory (drain); 0 = memory to buffer (fill).
REQ-018 SHALL have port copy_sector, output, 8 bits: sector to copy; stable while copy_req is high.
REQ-019 SHALL have port copy_done, input, 1 bit: one-cycle pulse marking copy completion.
REQ-020 SHALL have port busy, output, 1 bit: high whenever the sequencer is not in IDLE.

Function
REQ-021 SHALL implement the states IDLE, FILL, WAIT_N64, DRAIN, C2 and ERROR.
REQ-022 IDLE with bm_start_pending=1: SHALL pulse bm_start_clear in the next cycle and load cur_sector=sector_num, blk=0 (blk=1 if sector_num>=BLOCK1_BASE).
REQ-023 Start with disk_inserted=0: SHALL go to ERROR, set bm_micro_error=1, pulse bm_ready once, then return to IDLE; bm_micro_error holds until the next start.
REQ-024 Read-mode start: SHALL enter FILL with copy_req=1, copy_write=0, copy_sector=cur_sector.
REQ-025 FILL on copy_done: SHALL drop copy_req the same cycle, set bm_transfer_data=1, pulse bm_ready, and enter WAIT_N64.
REQ-026 Write-mode start: SHALL set bm_transfer_data=1, pulse bm_ready, and enter WAIT_N64.
REQ-027 WAIT_N64 on bm_pending=1: SHALL pulse bm_clear; read mode advances the sector, write mode enters DRAIN (copy_req=1, copy_write=1).
REQ-028 DRAIN on copy_done: SHALL advance the sector.
REQ-029 Sector advance: SHALL compute last = (cur_sector − blk*BLOCK1_BASE == DATA_SECTORS−1), using 8-bit arithmetic with no wrap past 255.
REQ-030 Advance with last=0: SHALL set cur_sector+=1 and go to FILL (read) or pulse bm_ready and go to WAIT_N64 (write).
REQ-031 Advance with last=1 in read mode: SHALL set bm_transfer_data=0 and bm_transfer_c2=1, pulse bm_ready, and enter C2.
REQ-032 C2 on bm_pending: SHALL pulse bm_clear, set bm_transfer_c2=0, then continue via REQ-033 or REQ-034.
REQ-033 Block end with bm_transfer_blocks=1 and blk=0: SHALL set blk=1, cur_sector=BLOCK1_BASE and continue.
REQ-034 Any other block end: SHALL return to IDLE with bm_transfer_data=0.
REQ-035 Write mode at last=1: SHALL skip C2 and apply REQ-033/034 directly.
REQ-036 bm_stop_pending=1 in any state: SHALL have priority over all other events, including a simultaneous copy_done or bm_pending.
REQ-037 On stop: SHALL pulse bm_stop_clear, drop copy_req, clear bm_transfer_data and bm_transfer_c2, and go to IDLE; a copy_done arriving later is ignored.
REQ-038 Simultaneous bm_start_pending and bm_stop_pending: SHALL apply the stop only; the start stays pending for the next cycle in IDLE.
REQ-039 bm_pending outside WAIT_N64/C2: SHALL be ignored and not cleared.
REQ-040 At most one of bm_ready, bm_clear, bm_start_clear and bm_stop_clear SHALL be asserted per cycle, except bm_clear with bm_ready on an advance.

Reset
REQ-041 reset=1: SHALL set state=IDLE and drive all outputs and the counters to 0 on the next edge, abandoning any copy in flight.
REQ-042 After reset: SHALL accept a start no earlier than one cycle after reset deasserts.

Verification
REQ-043 Read, sector_num=0, blocks=0, copy engine replies after 10 cycles: SHALL give 85 FILL/bm_ready/bm_clear cycles, then bm_transfer_c2 with 1 bm_ready, then IDLE.
REQ-044 Write, sector_num=90: SHALL pulse bm_ready, then on each bm_pending issue copy_write=1 for sectors 90..174, then IDLE with no C2.
REQ-045 Read, blocks=1, sector_num=84: SHALL cover sector 84, then C2, then sectors 90..174, then C2, then IDLE.
REQ-046 Stop asserted in the same cycle as copy_done in FILL: SHALL pulse bm_stop_clear, give no bm_ready, and return to IDLE.
REQ-047 Start with disk_inserted=0: SHALL set bm_micro_error=1 with one bm_ready pulse and no copy_req.
REQ-048 Reset pulsed in DRAIN: SHALL clear all outputs the next cycle, and a following start SHALL work normally.
